// File: rtl/index_loop_counter_if.sv
// Control and status bundle for the nested index down-counter.
`timescale 1ns/1ps

interface index_loop_counter_if #(
    parameter int unsigned OC_W = 4,
    parameter int unsigned KH_W = 2,
    parameter int unsigned KW_W = 2
);
    localparam int unsigned TOT_W = OC_W + KH_W + KW_W;

    logic              init;
    logic [OC_W-1:0]   bound_oc;
    logic [KH_W-1:0]   bound_kh;
    logic [KW_W-1:0]   bound_kw;
    logic              auto_reload;
    logic              enable;

    logic              busy;
    logic [OC_W-1:0]   idx_oc;
    logic [KH_W-1:0]   idx_kh;
    logic [KW_W-1:0]   idx_kw;
    logic [TOT_W-1:0]  remaining;
    logic              last;
    logic              near_last;
    logic              done;

    modport master (
        output init, bound_oc, bound_kh, bound_kw, auto_reload, enable,
        input  busy, idx_oc, idx_kh, idx_kw, remaining, last, near_last, done
    );

    modport slave (
        input  init, bound_oc, bound_kh, bound_kw, auto_reload, enable,
        output busy, idx_oc, idx_kh, idx_kw, remaining, last, near_last, done
    );
endinterface

// File: rtl/index_loop_counter.sv
// Nested {oc, kh, kw} down-counter producing decoded index tuples for one convolution
// window sweep, with remaining-step count, last/near-last flags and optional auto-reload.
`timescale 1ns/1ps

module index_loop_counter #(
    parameter int unsigned OC_W = 4,
    parameter int unsigned KH_W = 2,
    parameter int unsigned KW_W = 2
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    index_loop_counter_if.slave bus
);
    localparam int unsigned TOT_W  = OC_W + KH_W + KW_W;
    localparam int unsigned PROD_W = TOT_W + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [OC_W-1:0]   bnd_oc_q;
    logic [KH_W-1:0]   bnd_kh_q;
    logic [KW_W-1:0]   bnd_kw_q;
    logic              auto_q;
    logic [OC_W-1:0]   idx_oc_q;
    logic [KH_W-1:0]   idx_kh_q;
    logic [KW_W-1:0]   idx_kw_q;
    logic [TOT_W-1:0]  rem_q;
    logic              done_q;

    // A zero bound means 2^W: prefixing the zero-detect bit yields exactly that count.
    logic [OC_W:0]     eff_oc_in, eff_oc_lat;
    logic [KH_W:0]     eff_kh_in, eff_kh_lat;
    logic [KW_W:0]     eff_kw_in, eff_kw_lat;
    logic [PROD_W-1:0] prod_in, prod_lat;
    logic [TOT_W-1:0]  rem_load_in, rem_load_lat;

    assign eff_oc_in  = {(bus.bound_oc == '0), bus.bound_oc};
    assign eff_kh_in  = {(bus.bound_kh == '0), bus.bound_kh};
    assign eff_kw_in  = {(bus.bound_kw == '0), bus.bound_kw};
    assign eff_oc_lat = {(bnd_oc_q == '0), bnd_oc_q};
    assign eff_kh_lat = {(bnd_kh_q == '0), bnd_kh_q};
    assign eff_kw_lat = {(bnd_kw_q == '0), bnd_kw_q};

    // The product never exceeds 2^TOT_W, so TOT_W+1 bits hold it exactly.
    assign prod_in  = PROD_W'(eff_oc_in) * PROD_W'(eff_kh_in) * PROD_W'(eff_kw_in);
    assign prod_lat = PROD_W'(eff_oc_lat) * PROD_W'(eff_kh_lat) * PROD_W'(eff_kw_lat);

    assign rem_load_in  = TOT_W'(prod_in - PROD_W'(1));
    assign rem_load_lat = TOT_W'(prod_lat - PROD_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            bnd_oc_q <= '0;
            bnd_kh_q <= '0;
            bnd_kw_q <= '0;
            auto_q   <= 1'b0;
            idx_oc_q <= '0;
            idx_kh_q <= '0;
            idx_kw_q <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.init) begin
                // Restart wins over stepping and suppresses any pending done.
                bnd_oc_q <= bus.bound_oc;
                bnd_kh_q <= bus.bound_kh;
                bnd_kw_q <= bus.bound_kw;
                auto_q   <= bus.auto_reload;
                idx_oc_q <= bus.bound_oc - OC_W'(1);
                idx_kh_q <= bus.bound_kh - KH_W'(1);
                idx_kw_q <= bus.bound_kw - KW_W'(1);
                rem_q    <= rem_load_in;
                state_q  <= StRun;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StIdle;
                    end
                    StRun: begin
                        if (bus.enable) begin
                            if (rem_q == '0) begin
                                done_q <= 1'b1;
                                if (auto_q) begin
                                    idx_oc_q <= bnd_oc_q - OC_W'(1);
                                    idx_kh_q <= bnd_kh_q - KH_W'(1);
                                    idx_kw_q <= bnd_kw_q - KW_W'(1);
                                    rem_q    <= rem_load_lat;
                                end else begin
                                    idx_oc_q <= '0;
                                    idx_kh_q <= '0;
                                    idx_kw_q <= '0;
                                    rem_q    <= '0;
                                    state_q  <= StIdle;
                                end
                            end else begin
                                rem_q <= rem_q - TOT_W'(1);
                                if (idx_kw_q == '0) begin
                                    idx_kw_q <= bnd_kw_q - KW_W'(1);
                                    if (idx_kh_q == '0) begin
                                        idx_kh_q <= bnd_kh_q - KH_W'(1);
                                        idx_oc_q <= idx_oc_q - OC_W'(1);
                                    end else begin
                                        idx_kh_q <= idx_kh_q - KH_W'(1);
                                    end
                                end else begin
                                    idx_kw_q <= idx_kw_q - KW_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = (state_q == StRun);
    assign bus.idx_oc    = idx_oc_q;
    assign bus.idx_kh    = idx_kh_q;
    assign bus.idx_kw    = idx_kw_q;
    assign bus.remaining = rem_q;
    assign bus.done      = done_q;
    assign bus.last      = bus.busy & (rem_q == '0);

    // Gated by reset so every output reads 0 while reset is held.
    assign bus.near_last = rst_ni & ((bus.init & (prod_in == PROD_W'(1))) |
                                     (~bus.init & bus.busy & (rem_q <= TOT_W'(1))));

`ifndef SYNTHESIS
    a_done_cause: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.done |-> $past(bus.last && bus.enable && !bus.init));

    a_idx_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.busy |-> (({1'b0, idx_kw_q} < eff_kw_lat) &&
                      ({1'b0, idx_kh_q} < eff_kh_lat) &&
                      ({1'b0, idx_oc_q} < eff_oc_lat)));
`endif

endmodule

// File: tb/tb_index_loop_counter.sv
// Scoreboard bench for index_loop_counter: a reference sweep model queues expected tuples.
`timescale 1ns/1ps

module tb_index_loop_counter;
    localparam int unsigned OC_W = 4;
    localparam int unsigned KH_W = 2;
    localparam int unsigned KW_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    index_loop_counter_if #(.OC_W(OC_W), .KH_W(KH_W), .KW_W(KW_W)) bus ();

    index_loop_counter #(.OC_W(OC_W), .KH_W(KH_W), .KW_W(KW_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int oc;
        int kh;
        int kw;
        int rem;
    } tup_t;

    tup_t exp_q[$];
    int   total;
    int   bad;
    bit   exp_busy;
    bit   exp_done;
    bit   m_auto;
    int   m_oc, m_kh, m_kw;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int b, input int w);
        return (b == 0) ? (1 << w) : b;
    endfunction

    task automatic push_sweep();
        tup_t t;
        int   r;
        r = m_oc * m_kh * m_kw - 1;
        for (int a = m_oc - 1; a >= 0; a--)
            for (int b = m_kh - 1; b >= 0; b--)
                for (int c = m_kw - 1; c >= 0; c--) begin
                    t.oc  = a;
                    t.kh  = b;
                    t.kw  = c;
                    t.rem = r;
                    r--;
                    exp_q.push_back(t);
                end
    endtask

    // Called at a falling edge: compare current outputs, drive enable, advance the model.
    task automatic tick(input bit en);
        tup_t t;
        check_val("busy", int'(bus.busy), int'(exp_busy));
        check_val("done", int'(bus.done), int'(exp_done));
        if (exp_busy) begin
            if (exp_q.size() == 0) begin
                check_val("sb_empty", exp_q.size(), 1);
            end else begin
                t = exp_q[0];
                check_val("idx_oc", int'(bus.idx_oc), t.oc);
                check_val("idx_kh", int'(bus.idx_kh), t.kh);
                check_val("idx_kw", int'(bus.idx_kw), t.kw);
                check_val("remaining", int'(bus.remaining), t.rem);
                check_val("last", int'(bus.last), int'(t.rem == 0));
                check_val("near_last", int'(bus.near_last), int'(t.rem <= 1));
            end
        end else begin
            check_val("idle_oc", int'(bus.idx_oc), 0);
            check_val("idle_kh", int'(bus.idx_kh), 0);
            check_val("idle_kw", int'(bus.idx_kw), 0);
            check_val("idle_rem", int'(bus.remaining), 0);
            check_val("idle_last", int'(bus.last), 0);
            check_val("idle_near", int'(bus.near_last), 0);
        end
        bus.enable = en;
        exp_done = 1'b0;
        if (exp_busy && en && exp_q.size() > 0) begin
            t = exp_q.pop_front();
            if (t.rem == 0) begin
                exp_done = 1'b1;
                if (m_auto) push_sweep();
                else exp_busy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_init(input int oc, input int kh, input int kw, input bit ar,
                           input bit en);
        bus.init        = 1'b1;
        bus.bound_oc    = OC_W'(oc);
        bus.bound_kh    = KH_W'(kh);
        bus.bound_kw    = KW_W'(kw);
        bus.auto_reload = ar;
        bus.enable      = en;
        m_oc   = eff(oc, OC_W);
        m_kh   = eff(kh, KH_W);
        m_kw   = eff(kw, KW_W);
        m_auto = ar;
        #1;
        check_val("near_last_init", int'(bus.near_last), int'(m_oc * m_kh * m_kw == 1));
        @(negedge clk);
        bus.init   = 1'b0;
        bus.enable = 1'b0;
        exp_q.delete();
        push_sweep();
        exp_busy = 1'b1;
        exp_done = 1'b0;
    endtask

    initial begin
        bus.init        = 1'b0;
        bus.bound_oc    = '0;
        bus.bound_kh    = '0;
        bus.bound_kw    = '0;
        bus.auto_reload = 1'b0;
        bus.enable      = 1'b0;
        total    = 0;
        bad      = 0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        m_auto   = 1'b0;

        #12;
        check_val("rst_busy", int'(bus.busy), 0);
        check_val("rst_rem", int'(bus.remaining), 0);
        #5 rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a sweep.
        do_init(3, 3, 3, 1'b0, 1'b0);
        repeat (5) tick(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_busy", int'(bus.busy), 0);
        check_val("arst_oc", int'(bus.idx_oc), 0);
        check_val("arst_kh", int'(bus.idx_kh), 0);
        check_val("arst_kw", int'(bus.idx_kw), 0);
        check_val("arst_rem", int'(bus.remaining), 0);
        check_val("arst_last", int'(bus.last), 0);
        check_val("arst_near", int'(bus.near_last), 0);
        check_val("arst_done", int'(bus.done), 0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        repeat (3) tick(1'b1);

        // Full sweep (2,3,3): 18 tuples.
        do_init(2, 3, 3, 1'b0, 1'b0);
        check_val("first_oc", int'(bus.idx_oc), 1);
        check_val("first_kh", int'(bus.idx_kh), 2);
        check_val("first_kw", int'(bus.idx_kw), 2);
        check_val("first_rem", int'(bus.remaining), 17);
        repeat (18) tick(1'b1);
        tick(1'b0);
        tick(1'b0);

        // Zero bounds mean maximum counts: 256 steps.
        do_init(0, 0, 0, 1'b0, 1'b0);
        check_val("max_rem", int'(bus.remaining), 255);
        repeat (256) tick(1'b1);
        tick(1'b0);
        tick(1'b0);

        // Single-step sweep.
        do_init(1, 1, 1, 1'b0, 1'b0);
        check_val("single_last", int'(bus.last), 1);
        tick(1'b1);
        check_val("single_done", int'(bus.done), 1);
        tick(1'b0);

        // Auto-reload: two full 4-tuple windows plus two steps.
        do_init(1, 2, 2, 1'b1, 1'b0);
        repeat (10) tick(1'b1);
        check_val("auto_busy", int'(bus.busy), 1);
        tick(1'b0);

        // init together with enable: init wins, no step taken.
        do_init(1, 2, 2, 1'b0, 1'b1);
        check_val("ie_rem", int'(bus.remaining), 3);
        check_val("ie_kw", int'(bus.idx_kw), 1);
        repeat (3) tick(1'b0);
        repeat (3) tick(1'b1);

        // init while on the final tuple: restart with no done pulse.
        check_val("pre_reinit_last", int'(bus.last), 1);
        do_init(2, 2, 2, 1'b0, 1'b0);
        check_val("reinit_done", int'(bus.done), 0);
        repeat (8) tick(1'b1);
        tick(1'b0);
        tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
